// File: rtl/dmem_pkg.sv
// Shared types for the multi-cycle data-memory responder: FSM states, access op, counter sizing.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  function automatic int cnt_w(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/dmem_wbuf.sv
// One-entry posted-write buffer: holds a write for LATENCY cycles, then pulses o_commit for one cycle.
module dmem_wbuf
  import dmem_pkg::*;
#(
  parameter int AW      = 5,
  parameter int LATENCY = 3
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          i_push,
  input  logic [AW-1:0] i_idx,
  input  logic [31:0]   i_data,
  output logic          o_full,
  output logic          o_commit,
  output logic [AW-1:0] o_idx,
  output logic [31:0]   o_data
);

  localparam int CW = cnt_w(LATENCY);

  logic          r_full;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_data;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_full  <= 1'b0;
      r_count <= '0;
      r_idx   <= '0;
      r_data  <= '0;
    end else if (i_push) begin
      r_full  <= 1'b1;
      r_count <= CW'(LATENCY - 1);
      r_idx   <= i_idx;
      r_data  <= i_data;
    end else if (r_full) begin
      if (r_count == '0) r_full <= 1'b0;
      else               r_count <= r_count - 1'b1;
    end
  end

  assign o_full   = r_full;
  assign o_commit = r_full && (r_count == '0);
  assign o_idx    = r_idx;
  assign o_data   = r_data;

endmodule

// File: rtl/data_memory_responder.sv
// Slow-SRAM data memory behind the MEM-stage port: one access in flight, stall_o freezes the pipeline.
// Optional DMEM_WBUF_EN adds a one-entry posted-write buffer so plain stores do not stall.
module data_memory_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int LATENCY = 3
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] address_i,
  input  logic        Memory_read_i,
  input  logic        Memory_write_i,
  input  logic [31:0] write_data_i,
  output logic [31:0] read_data_o,
  output logic        stall_o,
  output logic        err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(LATENCY);

  state_t        r_state, w_next;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_data;
  op_t           r_op;
  logic          r_err;
  logic [31:0]   r_rdata;
  logic [31:0]   r_mem [DEPTH];

  logic          w_req, w_accept, w_commit, w_idle;
  logic [AW-1:0] w_idx, w_c_idx;
  logic [31:0]   w_c_data;
  op_t           w_c_op;
  logic          w_unused_addr;

  logic          w_wb_push, w_wb_full, w_wb_commit;
  logic [AW-1:0] w_wb_idx;
  logic [31:0]   w_wb_data;

  assign w_req         = Memory_read_i | Memory_write_i;
  assign w_idx         = address_i[AW+1:2];
  assign w_unused_addr = ^{address_i[31:AW+2], address_i[1:0]};
  assign w_idle        = (r_state == IDLE);

`ifdef DMEM_WBUF_EN
  assign w_wb_push = w_idle && Memory_write_i && !Memory_read_i && !w_wb_full;

  dmem_wbuf #(.AW(AW), .LATENCY(LATENCY)) u_wbuf (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .i_push   (w_wb_push),
    .i_idx    (w_idx),
    .i_data   (write_data_i),
    .o_full   (w_wb_full),
    .o_commit (w_wb_commit),
    .o_idx    (w_wb_idx),
    .o_data   (w_wb_data)
  );
`else
  assign w_wb_push   = 1'b0;
  assign w_wb_full   = 1'b0;
  assign w_wb_commit = 1'b0;
  assign w_wb_idx    = '0;
  assign w_wb_data   = '0;
`endif

  // Anything waiting behind a buffered write is held off until the buffer drains.
  assign w_accept = w_idle && w_req && !w_wb_full && !w_wb_push;

  // LATENCY==1 commits straight out of IDLE, so the commit path can take live inputs.
  assign w_commit = (w_accept && (LATENCY == 1)) ||
                    ((r_state == BUSY) && (r_count == CW'(1)));
  assign w_c_idx  = w_idle ? w_idx : r_idx;
  assign w_c_data = w_idle ? write_data_i : r_data;
  assign w_c_op   = w_idle ? (Memory_write_i ? OP_WR : OP_RD) : r_op;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = (LATENCY == 1) ? DONE : BUSY;
      BUSY:    if (r_count == CW'(1)) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    stall_o = 1'b0;
    case (r_state)
      IDLE:    stall_o = w_req && !w_wb_push;
      BUSY:    stall_o = 1'b1;
      default: stall_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_count <= '0;
      r_idx   <= '0;
      r_data  <= '0;
      r_op    <= OP_RD;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_err <= w_accept && Memory_read_i && Memory_write_i;
      if (w_accept) begin
        r_count <= CW'(LATENCY - 1);
        r_idx   <= w_idx;
        r_data  <= write_data_i;
        r_op    <= Memory_write_i ? OP_WR : OP_RD;
      end else if (r_state == BUSY) begin
        r_count <= r_count - 1'b1;
      end
      if (w_commit && (w_c_op == OP_RD)) r_rdata <= r_mem[w_c_idx];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_commit && (w_c_op == OP_WR)) r_mem[w_c_idx] <= w_c_data;
      if (w_wb_commit)                   r_mem[w_wb_idx] <= w_wb_data;
    end
  end

  assign read_data_o = r_rdata;
  assign err_o       = r_err;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder with a bench-side memory model and read-data scoreboard.
module tb_data_memory_responder;

  localparam int DEPTH   = 32;
  localparam int LATENCY = 3;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic [31:0] address_i;
  logic        Memory_read_i;
  logic        Memory_write_i;
  logic [31:0] write_data_i;
  logic [31:0] read_data_o;
  logic        stall_o;
  logic        err_o;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] exp_rd;
  logic [31:0] sb [$];

  data_memory_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n_i),
    .address_i      (address_i),
    .Memory_read_i  (Memory_read_i),
    .Memory_write_i (Memory_write_i),
    .write_data_i   (write_data_i),
    .read_data_o    (read_data_o),
    .stall_o        (stall_o),
    .err_o          (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    Memory_read_i  = 1'b0;
    Memory_write_i = 1'b0;
    address_i      = '0;
    write_data_i   = '0;
  endtask

  // One access: drive at a falling edge, wait for stall_o to drop, score read_data_o in DONE.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
    int          cyc;
    int          errs;
    logic        done;
    logic [4:0]  idx;
    logic [31:0] exp;
    idx = addr[6:2];
    @(negedge clk);
    Memory_read_i  = rd;
    Memory_write_i = wr;
    address_i      = addr;
    write_data_i   = data;
    if (wr) model[idx] = data;
    else if (rd) exp_rd = model[idx];
    sb.push_back(exp_rd);
    #1;
    chk("stall_accept_cycle", {31'b0, stall_o}, 32'd1);
    errs = err_o ? 1 : 0;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      if (err_o) errs++;
      if (!stall_o) done = 1'b1;
    end
    chk("done_reached", {31'b0, done}, 32'd1);
    chk("stall_cycles", 32'(cyc), 32'(LATENCY));
    chk("err_pulses", 32'(errs), (rd && wr) ? 32'd1 : 32'd0);
    exp = (sb.size() > 0) ? sb.pop_front() : 32'hx;
    chk("read_data_done", read_data_o, exp);
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    exp_rd = '0;
    clear_inputs();
    rst_n_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_read_data", read_data_o, 32'd0);
    chk("reset_stall", {31'b0, stall_o}, 32'd0);
    chk("reset_err", {31'b0, err_o}, 32'd0);
    @(negedge clk);
    rst_n_i = 1'b1;

    access(1'b1, 1'b0, 32'h8, 32'h0);

    // Reset while the write is in BUSY: nothing commits.
    @(negedge clk);
    Memory_write_i = 1'b1;
    address_i      = 32'h18;
    write_data_i   = 32'h77;
    @(posedge clk);
    #1;
    chk("midreset_busy_stall", {31'b0, stall_o}, 32'd1);
    #2;
    rst_n_i = 1'b0;
    clear_inputs();
    #1;
    chk("midreset_stall", {31'b0, stall_o}, 32'd0);
    chk("midreset_read_data", read_data_o, 32'd0);
    @(negedge clk);
    rst_n_i = 1'b1;
    access(1'b1, 1'b0, 32'h18, 32'h0);

    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'h10, 32'h0);

    access(1'b0, 1'b1, 32'h80, 32'h1234);
    access(1'b1, 1'b0, 32'h00, 32'h0);

    access(1'b1, 1'b1, 32'h4, 32'h55);
    access(1'b1, 1'b0, 32'h4, 32'h0);

    for (int k = 0; k < 6; k++) begin
      logic [31:0] a;
      a = {$urandom_range(0, 63), 2'b00};
      access(1'b0, 1'b1, a, $urandom);
      access(1'b1, 1'b0, {$urandom_range(0, 7), 2'b00}, 32'h0);
      access(1'b1, 1'b0, a ^ 32'h80, 32'h0);
    end

`ifdef DMEM_WBUF_EN
    begin
      int   cyc;
      logic done;
      @(negedge clk);
      Memory_write_i = 1'b1;
      address_i      = 32'h20;
      write_data_i   = 32'hA5;
      model[8]       = 32'hA5;
      #1;
      chk("wbuf_write_no_stall", {31'b0, stall_o}, 32'd0);
      @(negedge clk);
      Memory_write_i = 1'b0;
      Memory_read_i  = 1'b1;
      exp_rd         = model[8];
      sb.push_back(exp_rd);
      #1;
      chk("wbuf_read_stalls", {31'b0, stall_o}, 32'd1);
      cyc  = 0;
      done = 1'b0;
      while (!done && cyc < 30) begin
        @(posedge clk);
        #1;
        cyc++;
        if (!stall_o) done = 1'b1;
      end
      chk("wbuf_done_reached", {31'b0, done}, 32'd1);
      chk("wbuf_read_data", read_data_o, (sb.size() > 0) ? sb.pop_front() : 32'hx);
      @(negedge clk);
      clear_inputs();
    end
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
